pwm_peripheral: RTL and testbench

//  Downstream consumer of the SPI register file: turns the five 8-bit control

---
 rtl/pwm_peripheral.sv | 90 +++++++++
 tb/tb_pwm_peripheral.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Turns the five 8-bit control registers into 16 channel drives. Each
//   channel is off, static-high, or PWM at a shared duty cycle. A prescaler
//   (CLK_DIV clk cycles per step) feeds an 8-bit period counter, so one PWM
//   period is 256*CLK_DIV clk cycles. Duty and PWM-mode selects are
//   double-buffered and only swap at the period boundary, so a period never
//   mixes old and new settings. Output enables are read live so that an
//   output can be switched off immediately.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   en_reg_out_7_0   output enable, channels 7..0
//   en_reg_out_15_8  output enable, channels 15..8
//   en_reg_pwm_7_0   mode select, channels 7..0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  mode select, channels 15..8
//   pwm_duty_cycle   duty, 0x00 = never high, 0xFF = always high
//   out              registered channel drives, bit i = channel i
//   period_start     one-cycle pulse in the first cycle of each period

module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    duty_q, duty_d;
   logic [15:0]   pwm_en_q, pwm_en_d;
   logic [15:0]   out_q, out_d;
   logic          period_start_q, period_start_d;

   logic          tick;
   logic          boundary;
   logic          pwm_sig;
   logic [15:0]   en_out;

   always_comb begin
      tick     = (presc_q == PRESC_MAX);
      boundary = tick && (cnt_q == 8'hFF);
      en_out   = {en_reg_out_15_8, en_reg_out_7_0};

      presc_d = tick ? '0 : presc_q + PW'(1);
      cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;

      duty_d         = boundary ? pwm_duty_cycle : duty_q;
      pwm_en_d       = boundary ? {en_reg_pwm_15_8, en_reg_pwm_7_0} : pwm_en_q;
      period_start_d = boundary;

      // 0xFF is special-cased so full duty has no low step at cnt=255.
      pwm_sig = (duty_q == 8'hFF) || (cnt_q < duty_q);

      // Enabled static channels are 1; enabled PWM channels follow pwm_sig.
      out_d = en_out & (~pwm_en_q | {16{pwm_sig}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q        <= '0;
         cnt_q          <= 8'h00;
         duty_q         <= 8'h00;
         pwm_en_q       <= 16'h0000;
         out_q          <= 16'h0000;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         duty_q         <= duty_d;
         pwm_en_q       <= pwm_en_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

   localparam int CLK_DIV = 13;
   localparam int PERIOD  = 256 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] en_out = 16'h0000;
   logic [15:0] en_pwm = 16'h0000;
   logic [7:0]  duty = 8'h00;
   logic [15:0] out;
   logic        period_start;

   int checks = 0;
   int errors = 0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_out[7:0]),
      .en_reg_out_15_8 (en_out[15:8]),
      .en_reg_pwm_7_0  (en_pwm[7:0]),
      .en_reg_pwm_15_8 (en_pwm[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   // Reference model: time since reset release in clk cycles; position in
   // the period follows from plain division.
   int          m_t = 0;
   logic [7:0]  m_duty = 8'h00;
   logic [15:0] m_en = 16'h0000;
   logic [15:0] exp_out = 16'h0000;
   logic        exp_ps = 1'b0;
   bit          model_live = 1'b0;

   always @(posedge clk) begin
      int  pos;
      bit  sig;
      model_live = 1'b1;
      if (rst) begin
         m_t = 0; m_duty = 8'h00; m_en = 16'h0000;
         exp_out = 16'h0000; exp_ps = 1'b0;
      end else begin
         pos = (m_t / CLK_DIV) % 256;
         sig = (m_duty == 8'hFF) || (pos < int'(m_duty));
         for (int i = 0; i < 16; i++)
            exp_out[i] = en_out[i] ? (m_en[i] ? sig : 1'b1) : 1'b0;
         exp_ps = ((m_t % PERIOD) == PERIOD - 1);
         if (exp_ps) begin
            m_duty = duty;
            m_en   = en_pwm;
         end
         m_t++;
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         checks++;
         if (out !== exp_out || period_start !== exp_ps) begin
            errors++;
            $display("FAIL model t=%0d: out=%h ps=%b, expected out=%h ps=%b",
                     m_t, out, period_start, exp_out, exp_ps);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic wait_ps(input string name, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (period_start !== 1'b1 && waited < PERIOD + 50);
      if (period_start !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: no period_start within %0d cycles", name, waited);
      end
   endtask

   typedef struct {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [7:0]  duty;
      int          pwm_hi;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int w;
      int hi [16];
      int ps_cnt;
      int req;

      vecs[0] = '{16'hFFFF, 16'hFFFF, 8'h80, 1664};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 8'h00, 0};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 8'hFF, PERIOD};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 8'h01, 13};
      vecs[4] = '{16'h00FF, 16'h000F, 8'h40, 832};

      // Reset held with all inputs high.
      @(negedge clk);
      en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF;
      repeat (3) @(negedge clk);
      check("reset_out", 32'(out), 32'h0);
      check("reset_ps", 32'(period_start), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_static", 32'(out), 32'hFFFF);
      wait_ps("first_boundary", w);
      check("first_boundary_delay", 32'(w), 32'(PERIOD - 1));

      // Table vectors: load settings, let them swap in, measure one period.
      for (int v = 0; v < 5; v++) begin
         en_out = vecs[v].en_out;
         en_pwm = vecs[v].en_pwm;
         duty   = vecs[v].duty;
         wait_ps($sformatf("vec%0d_sync", v), w);
         for (int i = 0; i < 16; i++) hi[i] = 0;
         ps_cnt = 0;
         repeat (PERIOD) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) if (out[i]) hi[i]++;
            if (period_start) ps_cnt++;
         end
         for (int i = 0; i < 16; i++) begin
            req = !vecs[v].en_out[i] ? 0 : (vecs[v].en_pwm[i] ? vecs[v].pwm_hi : PERIOD);
            check($sformatf("vec%0d_ch%0d_high_cycles", v, i), 32'(hi[i]), 32'(req));
         end
         check($sformatf("vec%0d_ps_per_period", v), 32'(ps_cnt), 32'd1);
      end

      // Duty change at cnt=100: old shape finishes, new shape after boundary.
      en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h40;
      wait_ps("dchg_sync", w);
      repeat (100 * CLK_DIV) @(negedge clk);
      check("dchg_low_at_100", 32'(out[0]), 32'h0);
      duty = 8'hC0;
      repeat (50 * CLK_DIV) @(negedge clk);
      check("dchg_still_old", 32'(out), 32'h0);
      wait_ps("dchg_boundary", w);
      check("dchg_ps_cycle_old", 32'(out), 32'h0);
      @(negedge clk);
      check("dchg_new_high", 32'(out), 32'hFFFF);

      // Clearing an enable during the high phase takes effect next edge.
      repeat (10) @(negedge clk);
      check("clr_before", 32'(out[5]), 32'h1);
      en_out[5] = 1'b0;
      @(negedge clk);
      check("clr_after", 32'(out), 32'hFFDF);

      // Reset mid-period.
      repeat (400) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out", 32'(out), 32'h0);
      check("midrst_ps", 32'(period_start), 32'h0);
      rst = 1'b0;
      wait_ps("midrst_restart", w);
      check("midrst_restart_delay", 32'(w), 32'(PERIOD));

      // Randomised traffic against the reference model.
      repeat (12000) begin
         @(negedge clk);
         rst = ($urandom_range(0, 2999) == 0);
         if ($urandom_range(0, 63) == 0) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            case ($urandom_range(0, 3))
               0: duty = 8'h00;
               1: duty = 8'hFF;
               default: duty = 8'($urandom);
            endcase
         end
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
